dec_counter: RTL

//   Registered, loadable down-counter with programmable step; sequential successor to the DEC datapath component.

---
 rtl/dec_counter_if.sv | 27 ++
 rtl/dec_counter.sv | 83 ++++++++
 2 files changed

// File: rtl/dec_counter_if.sv
// Control/status bundle for dec_counter: load/decrement controls in, count and flags out.
// The master modport drives controls; the slave modport (the counter) drives status.
interface dec_counter_if #(
  parameter int DATAWIDTH = 64,
  parameter int STEPWIDTH = 8
);
  logic                 load;
  logic [DATAWIDTH-1:0] d_in;
  logic                 en;
  logic [STEPWIDTH-1:0] step;
  logic                 sat;
  logic                 clr_flags;
  logic [DATAWIDTH-1:0] q;
  logic                 zero;
  logic                 uf;
  logic                 uf_sticky;

  modport master (
    output load, d_in, en, step, sat, clr_flags,
    input  q, zero, uf, uf_sticky
  );

  modport slave (
    input  load, d_in, en, step, sat, clr_flags,
    output q, zero, uf, uf_sticky
  );
endinterface

// File: rtl/dec_counter.sv
// Loadable down-counter with programmable step, wrap or saturate-at-zero on borrow,
// registered zero flag, one-cycle underflow pulse and sticky underflow flag.
module dec_counter #(
  parameter int DATAWIDTH = 64,
  parameter int STEPWIDTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  dec_counter_if.slave  cnt_if
);

  if (DATAWIDTH < 2 || DATAWIDTH > 64) begin : g_bad_datawidth
    $error("dec_counter: DATAWIDTH=%0d outside legal range 2..64", DATAWIDTH);
  end

  if (STEPWIDTH < 1 || STEPWIDTH > DATAWIDTH) begin : g_bad_stepwidth
    $error("dec_counter: STEPWIDTH=%0d must be 1..DATAWIDTH (%0d)", STEPWIDTH, DATAWIDTH);
  end

  logic [DATAWIDTH-1:0] q_q, q_d;
  logic                 zero_q, zero_d;
  logic                 uf_q, uf_d;
  logic                 sticky_q, sticky_d;

  logic [DATAWIDTH:0]   step_ext;
  logic [DATAWIDTH:0]   diff;
  logic                 borrow;

  // One extra bit on the subtraction: its MSB is the borrow out of the count.
  assign step_ext = {{(DATAWIDTH + 1 - STEPWIDTH){1'b0}}, cnt_if.step};
  assign diff     = {1'b0, q_q} - step_ext;
  assign borrow   = diff[DATAWIDTH];

  always_comb begin
    q_d  = q_q;
    uf_d = 1'b0;
    if (cnt_if.load) begin
      q_d = cnt_if.d_in;
    end else if (cnt_if.en) begin
      uf_d = borrow;
      if (borrow && cnt_if.sat) begin
        q_d = '0;
      end else begin
        q_d = diff[DATAWIDTH-1:0];
      end
    end
  end

  // Zero flag tracks the value being registered so it lines up with q.
  always_comb begin
    zero_d = (q_d == '0);
  end

  // A fresh underflow outranks a clear requested in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    if (uf_d) begin
      sticky_d = 1'b1;
    end else if (cnt_if.clr_flags) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q      <= '0;
      zero_q   <= 1'b1;
      uf_q     <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      zero_q   <= zero_d;
      uf_q     <= uf_d;
      sticky_q <= sticky_d;
    end
  end

  assign cnt_if.q         = q_q;
  assign cnt_if.zero      = zero_q;
  assign cnt_if.uf        = uf_q;
  assign cnt_if.uf_sticky = sticky_q;

endmodule
